// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch path: FSM encodings, word size
// and the alignment mask used by the fetch address checker.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK  = 32'(INSTR_BYTES - 1);

  // Sequential successor; wraps modulo 2^32, the range check catches the result.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a fetch address: word alignment and upper
// bound. Kept standalone so the data-side MMU can reuse it.
module fetch_addr_check
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT = 32'h0001_0000
) (
  input  logic [31:0] addr,
  output logic        fault
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = (addr & ALIGN_MASK) != 32'd0;
  assign out_of_range = addr >= PC_LIMIT;
  assign fault        = misaligned | out_of_range;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch responder: owns the PC, issues one memory request at a
// time and holds one instruction word for the controlpath.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] instruction,
  output logic        wait_instr,
  output logic        instr_segv,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         redirect_q, redirect_d;
  logic         wait_q, wait_d;
  logic         segv_q, segv_d;
  logic         mem_req_q, mem_req_d;
  logic         pc_fault;

  fetch_addr_check #(
    .PC_LIMIT(PC_LIMIT)
  ) u_addr_check (
    .addr (pc_q),
    .fault(pc_fault)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ISSUE;
      pc_q       <= RESET_PC;
      target_q   <= RESET_PC;
      instr_q    <= 32'd0;
      mem_addr_q <= RESET_PC;
      redirect_q <= 1'b0;
      wait_q     <= 1'b1;
      segv_q     <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      instr_q    <= instr_d;
      mem_addr_q <= mem_addr_d;
      redirect_q <= redirect_d;
      wait_q     <= wait_d;
      segv_q     <= segv_d;
      mem_req_q  <= mem_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    instr_d    = instr_q;
    mem_addr_d = mem_addr_q;
    redirect_d = redirect_q;
    wait_d     = wait_q;
    segv_d     = segv_q;
    mem_req_d  = mem_req_q;

    unique case (state_q)
      ST_ISSUE: begin
        if (pc_load) begin
          pc_d = pc_target;
        end else if (pc_fault) begin
          state_d = ST_FAULT;
          segv_d  = 1'b1;
        end else begin
          state_d    = ST_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end

      ST_WAIT: begin
        // The bus request cannot be withdrawn, so a redirect is parked until
        // the ack arrives; the newest target always wins.
        if (pc_load) begin
          target_d   = pc_target;
          redirect_d = 1'b1;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (pc_load || redirect_q) begin
            pc_d       = pc_load ? pc_target : target_q;
            redirect_d = 1'b0;
            state_d    = ST_ISSUE;
          end else if (mem_err) begin
            state_d = ST_FAULT;
            segv_d  = 1'b1;
          end else begin
            instr_d = mem_rdata;
            wait_d  = 1'b0;
            state_d = ST_VALID;
          end
        end
      end

      ST_VALID: begin
        if (pc_load) begin
          pc_d    = pc_target;
          wait_d  = 1'b1;
          state_d = ST_ISSUE;
        end else if (pc_inc) begin
          pc_d    = next_pc(pc_q);
          wait_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_FAULT: begin
        if (pc_load) begin
          pc_d    = pc_target;
          segv_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end

      default: begin
        state_d = ST_ISSUE;
      end
    endcase
  end

  assign instruction = instr_q;
  assign wait_instr  = wait_q;
  assign instr_segv  = segv_q;
  assign pc          = pc_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run, all against a transaction-level model of the fetch contract.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_LIMIT = 32'h0001_0000;

  logic        clk;
  logic        reset;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] instruction;
  logic        wait_instr;
  logic        instr_segv;
  logic [31:0] pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  // Model: the address the controlpath expects to be fetched next, whether a
  // bus request is outstanding for it, and what the controlpath should see.
  logic [31:0] m_target, m_req_addr, m_instr;
  bit m_issue, m_inflight, m_valid, m_fault, m_stale;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .PC_LIMIT(PC_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .instruction(instruction),
    .wait_instr (wait_instr),
    .instr_segv (instr_segv),
    .pc         (pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic bit illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= PC_LIMIT);
  endfunction

  task automatic model_reset();
    m_target   = RESET_PC;
    m_req_addr = RESET_PC;
    m_instr    = 32'd0;
    m_issue    = 1'b1;
    m_inflight = 1'b0;
    m_valid    = 1'b0;
    m_fault    = 1'b0;
    m_stale    = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the contract's rules, then
  // step past the rising edge.
  task automatic cycle(input bit ld, input logic [31:0] tgt, input bit inc,
                       input bit ack, input bit err, input logic [31:0] rdata);
    pc_load = ld; pc_target = tgt; pc_inc = inc;
    mem_ack = ack; mem_err = err; mem_rdata = rdata;
    if (m_inflight) begin
      if (ld) begin
        m_target = tgt;
        m_stale  = 1'b1;
      end
      if (ack) begin
        m_inflight = 1'b0;
        if (m_stale) begin
          m_stale = 1'b0;
          m_issue = 1'b1;
          $display("fetch addr=%h discarded, redirect to %h", m_req_addr, m_target);
        end else if (err) begin
          m_fault = 1'b1;
          $display("fetch addr=%h bus error", m_req_addr);
        end else begin
          m_valid = 1'b1;
          m_instr = rdata;
          $display("fetch addr=%h data=%h", m_req_addr, rdata);
        end
      end
    end else if (m_issue) begin
      if (ld) begin
        m_target = tgt;
      end else if (illegal(m_target)) begin
        m_issue = 1'b0;
        m_fault = 1'b1;
        $display("fetch addr=%h illegal address", m_target);
      end else begin
        m_issue    = 1'b0;
        m_inflight = 1'b1;
        m_req_addr = m_target;
      end
    end else if (m_valid) begin
      if (ld) begin
        m_target = tgt; m_valid = 1'b0; m_issue = 1'b1;
      end else if (inc) begin
        m_target = m_target + 32'd4; m_valid = 1'b0; m_issue = 1'b1;
      end
    end else if (m_fault) begin
      if (ld) begin
        m_target = tgt; m_fault = 1'b0; m_issue = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    pc_load = 1'b0; pc_inc = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
  endtask

  // Zero-wait memory: acknowledges any pending request with its stored word.
  task automatic auto_cycle(input bit ld, input logic [31:0] tgt, input bit inc);
    cycle(ld, tgt, inc, mem_req, 1'b0, mem_word(mem_addr));
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_target = 32'd0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'd0;
    model_reset();
    #3;
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (instruction !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", instruction); end
    checks++; if (wait_instr !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b want 1", wait_instr); end
    checks++; if (instr_segv !== 1'b0) begin errors++; $display("FAIL reset_segv: got %b want 0", instr_segv); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got %b want 0", mem_req); end
    reset = 1'b0;
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    checks++; if (wait_instr !== 1'b0 || instruction !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL first_instr: got wait=%b instr=%h want wait=0 instr=deadbeef", wait_instr, instruction);
    end
  endtask

  task automatic test_pc_inc_stream();
    for (int k = 1; k <= 3; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      auto_cycle(1'b0, 32'd0, 1'b1);
      checks++; if (wait_instr !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL stream_issue: got wait=%b req=%b want wait=1 req=0", wait_instr, mem_req);
      end
      auto_cycle(1'b0, 32'd0, 1'b1);
      checks++; if (mem_req !== 1'b1 || mem_addr !== a) begin
        errors++; $display("FAIL stream_addr: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, a);
      end
      auto_cycle(1'b0, 32'd0, 1'b1);
      checks++; if (wait_instr !== 1'b0 || instruction !== mem_word(a) || pc !== a) begin
        errors++; $display("FAIL stream_data: got wait=%b instr=%h pc=%h want wait=0 instr=%h pc=%h",
                           wait_instr, instruction, pc, mem_word(a), a);
      end
    end
  endtask

  task automatic test_redirect_wait();
    auto_cycle(1'b0, 32'd0, 1'b1);
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL redir_req: got %h want 10", mem_addr); end
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || wait_instr !== 1'b1) begin
        errors++; $display("FAIL redir_hold: got req=%b addr=%h wait=%b want req=1 addr=10 wait=1",
                           mem_req, mem_addr, wait_instr);
      end
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1111_1111);
    checks++; if (instruction === 32'h1111_1111 || wait_instr !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL redir_discard: got instr=%h wait=%b req=%b want old instr, wait=1, req=0",
                         instruction, wait_instr, mem_req);
    end
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=100", mem_req, mem_addr);
    end
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (instruction !== mem_word(32'h100) || pc !== 32'h100) begin
      errors++; $display("FAIL redir_data: got instr=%h pc=%h want %h pc=100", instruction, pc, mem_word(32'h100));
    end
    // Two loads in one wait, the second coinciding with the ack.
    auto_cycle(1'b0, 32'd0, 1'b1);
    auto_cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h2222_2222);
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
      errors++; $display("FAIL redir_last_wins: got req=%b addr=%h want req=1 addr=300", mem_req, mem_addr);
    end
    auto_cycle(1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_bus_error();
    auto_cycle(1'b0, 32'd0, 1'b1);
    auto_cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h5555_5555);
    checks++; if (instr_segv !== 1'b1 || wait_instr !== 1'b1 || instruction !== mem_word(32'h300)) begin
      errors++; $display("FAIL err_fault: got segv=%b wait=%b instr=%h want segv=1 wait=1 instr=%h",
                         instr_segv, wait_instr, instruction, mem_word(32'h300));
    end
    for (int i = 0; i < 3; i++) begin
      auto_cycle(1'b0, 32'd0, 1'b1);
      checks++; if (instr_segv !== 1'b1 || pc !== 32'h304 || mem_req !== 1'b0) begin
        errors++; $display("FAIL err_inc_ignored: got segv=%b pc=%h req=%b want segv=1 pc=304 req=0",
                           instr_segv, pc, mem_req);
      end
    end
    auto_cycle(1'b1, 32'h40, 1'b0);
    checks++; if (instr_segv !== 1'b0) begin errors++; $display("FAIL err_clear: got segv=%b want 0", instr_segv); end
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL err_refetch: got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr);
    end
    auto_cycle(1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_range_fault();
    logic [31:0] bad [2];
    bad[0] = PC_LIMIT;
    bad[1] = 32'h0000_0002;
    for (int i = 0; i < 2; i++) begin
      auto_cycle(1'b1, bad[i], 1'b0);
      checks++; if (instr_segv !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL range_issue: got segv=%b req=%b want 0 0", instr_segv, mem_req);
      end
      auto_cycle(1'b0, 32'd0, 1'b0);
      checks++; if (instr_segv !== 1'b1 || wait_instr !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL range_fault: addr=%h got segv=%b wait=%b req=%b want 1 1 0",
                           bad[i], instr_segv, wait_instr, mem_req);
      end
    end
    auto_cycle(1'b1, 32'h0000_FFFC, 1'b0);
    auto_cycle(1'b0, 32'd0, 1'b0);
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (wait_instr !== 1'b0 || instruction !== mem_word(32'hFFFC)) begin
      errors++; $display("FAIL range_last_legal: got wait=%b instr=%h want 0 %h",
                         wait_instr, instruction, mem_word(32'hFFFC));
    end
    auto_cycle(1'b0, 32'd0, 1'b1);
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (instr_segv !== 1'b1 || pc !== PC_LIMIT || mem_req !== 1'b0) begin
      errors++; $display("FAIL range_inc_over: got segv=%b pc=%h req=%b want 1 %h 0",
                         instr_segv, pc, mem_req, PC_LIMIT);
    end
    auto_cycle(1'b1, 32'h80, 1'b0);
    auto_cycle(1'b0, 32'd0, 1'b0);
    auto_cycle(1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid_request();
    auto_cycle(1'b0, 32'd0, 1'b1);
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_setup: got req=%b want 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (mem_req !== 1'b0 || pc !== RESET_PC) begin
      errors++; $display("FAIL midrst_async: got req=%b pc=%h want req=0 pc=%h", mem_req, pc, RESET_PC);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    checks++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC || wait_instr !== 1'b1) begin
      errors++; $display("FAIL midrst_stale: got req=%b addr=%h wait=%b want 1 %h 1",
                         mem_req, mem_addr, wait_instr, RESET_PC);
    end
    auto_cycle(1'b0, 32'd0, 1'b0);
    checks++; if (wait_instr !== 1'b0 || instruction !== mem_word(RESET_PC)) begin
      errors++; $display("FAIL midrst_refetch: got wait=%b instr=%h want 0 %h",
                         wait_instr, instruction, mem_word(RESET_PC));
    end
  endtask

  task automatic test_random();
    int settle;
    for (int n = 0; n < 600; n++) begin
      bit ld, inc, ack, err;
      logic [31:0] tgt;
      ld  = ($urandom % 8) == 0;
      inc = ($urandom % 2) == 1;
      ack = mem_req && (($urandom % 3) == 0);
      err = ($urandom % 10) == 0;
      case ($urandom % 8)
        0:       tgt = $urandom;
        1:       tgt = 32'h0000_FFFC;
        2:       tgt = PC_LIMIT;
        default: tgt = $urandom_range(0, 32'h3FFF) << 2;
      endcase
      cycle(ld, tgt, inc, ack, err, $urandom);
      checks++; if (mem_req !== m_inflight) begin
        errors++; $display("FAIL rnd_req: cycle %0d got %b want %b", n, mem_req, m_inflight);
      end
      checks++; if (m_inflight && mem_addr !== m_req_addr) begin
        errors++; $display("FAIL rnd_addr: cycle %0d got %h want %h", n, mem_addr, m_req_addr);
      end
      checks++; if (wait_instr !== !m_valid) begin
        errors++; $display("FAIL rnd_wait: cycle %0d got %b want %b", n, wait_instr, !m_valid);
      end
      checks++; if (instr_segv !== m_fault) begin
        errors++; $display("FAIL rnd_segv: cycle %0d got %b want %b", n, instr_segv, m_fault);
      end
      checks++; if (instruction !== m_instr) begin
        errors++; $display("FAIL rnd_instr: cycle %0d got %h want %h", n, instruction, m_instr);
      end
      checks++; if (pc !== (m_inflight ? m_req_addr : m_target)) begin
        errors++; $display("FAIL rnd_pc: cycle %0d got %h want %h", n, pc, m_inflight ? m_req_addr : m_target);
      end
    end
    settle = 0;
    while (!(m_valid || m_fault) && settle < 10) begin
      auto_cycle(1'b0, 32'd0, 1'b0);
      settle++;
    end
    checks++; if (!(m_valid || m_fault) || wait_instr !== !m_valid || instr_segv !== m_fault) begin
      errors++; $display("FAIL rnd_settle: got wait=%b segv=%b after %0d cycles want a settled fetch",
                         wait_instr, instr_segv, settle);
    end
  endtask

  initial begin
    test_reset();
    test_pc_inc_stream();
    test_redirect_wait();
    test_bus_error();
    test_range_fault();
    test_reset_mid_request();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
